// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data SRAM port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {PORT_NONE, PORT_I, PORT_D} port_sel_e;

  localparam logic [3:0] BE_WORD   = 4'b1111;
  localparam int         MAX_ADD_W = 30;

  typedef struct packed {
    logic                 we;
    logic                 re;
    logic [3:0]           ble;
    logic [MAX_ADD_W-1:0] add;
    logic [31:0]          d;
  } mem_req_t;

  // Byte address to word index; callers keep only the low bits they need.
  function automatic logic [MAX_ADD_W-1:0] word_of(input logic [31:0] addr);
    return MAX_ADD_W'(addr >> 2);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and SRAM side of the arbiter bundled as one bus.
interface mem_port_arbiter_if #(
  parameter int SIZE = 4096
);
  localparam int AW = $clog2(SIZE);

  logic          i_req_i;
  logic [31:0]   i_addr_i;
  logic          i_gnt_o;
  logic          i_rvalid_o;
  logic [31:0]   i_rdata_o;
  logic          i_err_o;

  logic          d_req_i;
  logic          d_we_i;
  logic [3:0]    d_be_i;
  logic [31:0]   d_addr_i;
  logic [31:0]   d_wdata_i;
  logic          d_gnt_o;
  logic          d_rvalid_o;
  logic [31:0]   d_rdata_o;
  logic          d_err_o;

  logic          mem_we_o;
  logic          mem_re_o;
  logic [3:0]    mem_ble_o;
  logic [31:0]   mem_d_o;
  logic [AW-1:0] mem_add_o;
  logic [31:0]   mem_d_i;

  modport slave (
    input  i_req_i, i_addr_i,
    output i_gnt_o, i_rvalid_o, i_rdata_o, i_err_o,
    input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    output d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
    output mem_we_o, mem_re_o, mem_ble_o, mem_d_o, mem_add_o,
    input  mem_d_i
  );

  modport master (
    output i_req_i, i_addr_i,
    input  i_gnt_o, i_rvalid_o, i_rdata_o, i_err_o,
    output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    input  d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
    input  mem_we_o, mem_re_o, mem_ble_o, mem_d_o, mem_add_o,
    output mem_d_i
  );

endinterface

// File: rtl/mem_arb_resp_reg.sv
// Registered response (valid/data/error) for one requesting port.
module mem_arb_resp_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gnt,
  input  logic        rd,
  input  logic        oor,
  input  logic [31:0] rdata_in,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err
);

  // Data and error hold while the port is idle; only valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      err    <= 1'b0;
    end else if (gnt) begin
      rvalid <= 1'b1;
      rdata  <= rd ? rdata_in : '0;
      err    <= oor;
    end else begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port SRAM shared by instruction fetch and load/store, data-first with a fetch starvation guard.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int SIZE         = 4096,
  parameter int STARVE_LIMIT = 2
) (
  input logic               clk_i,
  input logic               rst_ni,
  mem_port_arbiter_if.slave bus
);

  localparam int AW = $clog2(SIZE);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  port_sel_e     sel;
  mem_req_t      req;
  logic [CW-1:0] starve_cnt;
  logic          i_in_range;
  logic          d_in_range;
  logic          unused_add_hi;

  assign i_in_range = bus.i_addr_i < 32'(SIZE);
  assign d_in_range = bus.d_addr_i < 32'(SIZE);

  always_comb begin
    sel = PORT_NONE;
    if (bus.d_req_i && (!bus.i_req_i || starve_cnt < LIMIT)) begin
      sel = PORT_D;
    end else if (bus.i_req_i) begin
      sel = PORT_I;
    end
  end

  // Out-of-range grants leave the SRAM bus fully idle.
  always_comb begin
    req = '0;
    case (sel)
      PORT_I: begin
        if (i_in_range) begin
          req.re  = 1'b1;
          req.ble = BE_WORD;
          req.add = word_of(bus.i_addr_i);
        end
      end
      PORT_D: begin
        if (d_in_range) begin
          req.we  = bus.d_we_i;
          req.re  = !bus.d_we_i;
          req.ble = bus.d_be_i;
          req.add = word_of(bus.d_addr_i);
          req.d   = bus.d_we_i ? bus.d_wdata_i : '0;
        end
      end
      default: req = '0;
    endcase
  end

  assign bus.i_gnt_o   = (sel == PORT_I);
  assign bus.d_gnt_o   = (sel == PORT_D);
  assign bus.mem_we_o  = req.we;
  assign bus.mem_re_o  = req.re;
  assign bus.mem_ble_o = req.ble;
  assign bus.mem_d_o   = req.d;
  assign bus.mem_add_o = req.add[AW-1:0];
  assign unused_add_hi = ^req.add;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt <= '0;
    end else if (bus.i_req_i && sel != PORT_I) begin
      starve_cnt <= (starve_cnt >= LIMIT) ? starve_cnt : starve_cnt + CW'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

  mem_arb_resp_reg u_i_resp (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .gnt      (sel == PORT_I),
    .rd       (i_in_range),
    .oor      (!i_in_range),
    .rdata_in (bus.mem_d_i),
    .rvalid   (bus.i_rvalid_o),
    .rdata    (bus.i_rdata_o),
    .err      (bus.i_err_o)
  );

  mem_arb_resp_reg u_d_resp (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .gnt      (sel == PORT_D),
    .rd       (d_in_range && !bus.d_we_i),
    .oor      (!d_in_range),
    .rdata_in (bus.mem_d_i),
    .rvalid   (bus.d_rvalid_o),
    .rdata    (bus.d_rdata_o),
    .err      (bus.d_err_o)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural lane-masked SRAM.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  logic        load_en;
  logic [11:0] load_idx;
  logic [31:0] load_val;
  logic [31:0] sram [0:4095];
  logic [31:0] lane_mask;

  mem_port_arbiter_if #(.SIZE(4096)) bus();

  mem_port_arbiter #(.SIZE(4096), .STARVE_LIMIT(2)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign lane_mask = {{8{bus.mem_ble_o[3]}}, {8{bus.mem_ble_o[2]}},
                      {8{bus.mem_ble_o[1]}}, {8{bus.mem_ble_o[0]}}};
  assign bus.mem_d_i = sram[bus.mem_add_o] & lane_mask;

  always @(posedge clk) begin
    if (load_en) begin
      sram[load_idx] <= load_val;
    end else if (bus.mem_we_o) begin
      sram[bus.mem_add_o] <= (sram[bus.mem_add_o] & ~lane_mask) | (bus.mem_d_o & lane_mask);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    load_en  = 1'b0;
    load_idx = '0;
    load_val = '0;
    bus.i_req_i   = 1'b0;
    bus.i_addr_i  = '0;
    bus.d_req_i   = 1'b0;
    bus.d_we_i    = 1'b0;
    bus.d_be_i    = '0;
    bus.d_addr_i  = '0;
    bus.d_wdata_i = '0;
    #1;
    check("rst_i_rvalid", 32'(bus.i_rvalid_o), 32'd0);
    check("rst_d_rvalid", 32'(bus.d_rvalid_o), 32'd0);
    check("rst_i_rdata",  bus.i_rdata_o,       32'd0);
    check("rst_d_rdata",  bus.d_rdata_o,       32'd0);
    check("rst_i_err",    32'(bus.i_err_o),    32'd0);
    check("rst_d_err",    32'(bus.d_err_o),    32'd0);

    // preload word 4 and word 8 while the arbiter is held in reset
    load_en = 1'b1; load_idx = 12'd4; load_val = 32'hDEADBEEF;
    step();
    load_idx = 12'd8; load_val = 32'hFFFFFFFF;
    step();
    load_en = 1'b0;
    rst_n   = 1'b1;
    step();

    bus.i_req_i = 1'b1; bus.i_addr_i = 32'h10;
    #1;
    check("fetch_i_gnt",   32'(bus.i_gnt_o),   32'd1);
    check("fetch_d_gnt",   32'(bus.d_gnt_o),   32'd0);
    check("fetch_add",     32'(bus.mem_add_o), 32'd4);
    check("fetch_ble",     32'(bus.mem_ble_o), 32'hF);
    check("fetch_re",      32'(bus.mem_re_o),  32'd1);
    step();
    bus.i_req_i = 1'b0;
    check("fetch_rvalid",  32'(bus.i_rvalid_o), 32'd1);
    check("fetch_rdata",   bus.i_rdata_o,       32'hDEADBEEF);
    check("fetch_err",     32'(bus.i_err_o),    32'd0);

    bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_be_i = 4'b0011;
    bus.d_addr_i = 32'h20; bus.d_wdata_i = 32'h12345678;
    #1;
    check("store_d_gnt", 32'(bus.d_gnt_o),   32'd1);
    check("store_we",    32'(bus.mem_we_o),  32'd1);
    check("store_re",    32'(bus.mem_re_o),  32'd0);
    check("store_ble",   32'(bus.mem_ble_o), 32'h3);
    check("store_d",     bus.mem_d_o,        32'h12345678);
    check("store_add",   32'(bus.mem_add_o), 32'd8);
    step();
    bus.d_we_i = 1'b0; bus.d_be_i = 4'b1111;
    #1;
    check("store_rvalid", 32'(bus.d_rvalid_o), 32'd1);
    check("store_rdata",  bus.d_rdata_o,       32'd0);
    check("store_err",    32'(bus.d_err_o),    32'd0);
    check("load_re",      32'(bus.mem_re_o),   32'd1);
    step();
    bus.d_req_i = 1'b0;
    check("raw_rvalid", 32'(bus.d_rvalid_o), 32'd1);
    check("raw_rdata",  bus.d_rdata_o,       32'hFFFF5678);
    step();
    check("idle_d_rvalid", 32'(bus.d_rvalid_o), 32'd0);
    check("idle_d_hold",   bus.d_rdata_o,       32'hFFFF5678);

    // both ports busy: expected grants D,D,I repeating
    bus.i_req_i = 1'b1; bus.i_addr_i = 32'h10;
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_be_i = 4'b1111; bus.d_addr_i = 32'h20;
    for (int k = 0; k < 9; k++) begin
      #1;
      check($sformatf("starve_i_gnt_%0d", k), 32'(bus.i_gnt_o), (k % 3 == 2) ? 32'd1 : 32'd0);
      check($sformatf("starve_d_gnt_%0d", k), 32'(bus.d_gnt_o), (k % 3 == 2) ? 32'd0 : 32'd1);
      step();
      check($sformatf("starve_i_rv_%0d", k), 32'(bus.i_rvalid_o), (k % 3 == 2) ? 32'd1 : 32'd0);
      check($sformatf("starve_d_rv_%0d", k), 32'(bus.d_rvalid_o), (k % 3 == 2) ? 32'd0 : 32'd1);
    end
    check("starve_i_rdata", bus.i_rdata_o, 32'hDEADBEEF);
    check("starve_d_rdata", bus.d_rdata_o, 32'hFFFF5678);
    bus.i_req_i = 1'b0; bus.d_req_i = 1'b0;
    step();

    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_be_i = 4'b1111; bus.d_addr_i = 32'h1000;
    #1;
    check("oor_d_gnt", 32'(bus.d_gnt_o),   32'd1);
    check("oor_re",    32'(bus.mem_re_o),  32'd0);
    check("oor_we",    32'(bus.mem_we_o),  32'd0);
    check("oor_ble",   32'(bus.mem_ble_o), 32'd0);
    check("oor_add",   32'(bus.mem_add_o), 32'd0);
    step();
    bus.d_req_i = 1'b0;
    check("oor_d_rvalid", 32'(bus.d_rvalid_o), 32'd1);
    check("oor_d_err",    32'(bus.d_err_o),    32'd1);
    check("oor_d_rdata",  bus.d_rdata_o,       32'd0);

    bus.i_req_i = 1'b1; bus.i_addr_i = 32'h2000;
    #1;
    check("oor_i_gnt", 32'(bus.i_gnt_o),  32'd1);
    check("oor_i_re",  32'(bus.mem_re_o), 32'd0);
    step();
    bus.i_addr_i = 32'h13;
    check("oor_i_err",   32'(bus.i_err_o), 32'd1);
    check("oor_i_rdata", bus.i_rdata_o,    32'd0);
    step();
    bus.i_req_i = 1'b0;
    check("lowbits_i_rdata", bus.i_rdata_o,    32'hDEADBEEF);
    check("lowbits_i_err",   32'(bus.i_err_o), 32'd0);
    step();

    // reset lands between a fetch grant and its response edge
    bus.i_req_i = 1'b1; bus.i_addr_i = 32'h10;
    #1;
    check("mid_i_gnt", 32'(bus.i_gnt_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    bus.i_req_i = 1'b0;
    check("mid_i_rvalid", 32'(bus.i_rvalid_o), 32'd0);
    check("mid_i_rdata",  bus.i_rdata_o,       32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("post_i_rvalid", 32'(bus.i_rvalid_o), 32'd0);
    check("post_i_rdata",  bus.i_rdata_o,       32'd0);

    // raise the starvation count to its limit, then reset it away
    bus.i_req_i = 1'b1; bus.i_addr_i = 32'h10;
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_be_i = 4'b1111; bus.d_addr_i = 32'h20;
    #1;
    check("pre_d_gnt_0", 32'(bus.d_gnt_o), 32'd1);
    step();
    check("pre_d_gnt_1", 32'(bus.d_gnt_o), 32'd1);
    step();
    check("pre_i_gnt", 32'(bus.i_gnt_o), 32'd1);
    #2;
    rst_n = 1'b0;
    bus.i_req_i = 1'b0; bus.d_req_i = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    bus.i_req_i = 1'b1; bus.d_req_i = 1'b1;
    #1;
    check("cnt0_d_gnt", 32'(bus.d_gnt_o), 32'd1);
    check("cnt0_i_gnt", 32'(bus.i_gnt_o), 32'd0);
    step();
    bus.d_req_i = 1'b0;
    check("cnt0_i_rvalid", 32'(bus.i_rvalid_o), 32'd0);
    check("cnt0_d_rvalid", 32'(bus.d_rvalid_o), 32'd1);
    #1;
    check("solo_i_gnt", 32'(bus.i_gnt_o), 32'd1);
    step();
    bus.i_req_i = 1'b0;
    check("solo_i_rvalid", 32'(bus.i_rvalid_o), 32'd1);
    check("solo_d_rvalid", 32'(bus.d_rvalid_o), 32'd0);
    check("solo_i_rdata",  bus.i_rdata_o,       32'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port SRAM (synchronous write, asynchronous masked read, word-indexed) between the core's instruction-fetch port and its load/store port. It arbitrates every cycle and drives the SRAM control, byte-lane, address and data lines. It converts byte addresses to word indices, range-checks them, and returns registered read responses one cycle after grant. Default priority goes to the data port, with a starvation limit that guarantees fetch progress.

Parameters:
SIZE, 4096, memory size in bytes (power of two, same value as the SRAM instance)
STARVE_LIMIT, 2, consecutive denied fetch-request cycles before fetch wins the next conflict (>=1)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
i_req_i  in  1  fetch request; held with i_addr_i stable until i_gnt_o
i_addr_i  in  32  fetch byte address
i_gnt_o  out  1  fetch granted this cycle (combinational)
i_rvalid_o  out  1  fetch response valid (registered)
i_rdata_o  out  32  fetch read data
i_err_o  out  1  fetch address out of range; qualified by i_rvalid_o
d_req_i  in  1  data request; held with attributes stable until d_gnt_o
d_we_i  in  1  1 = store, 0 = load
d_be_i  in  4  byte enables
d_addr_i  in  32  data byte address
d_wdata_i  in  32  store data
d_gnt_o  out  1  data granted this cycle (combinational)
d_rvalid_o  out  1  data response valid (registered, loads and stores)
d_rdata_o  out  32  load data (0 for stores)
d_err_o  out  1  data address out of range; qualified by d_rvalid_o
mem_we_o  out  1  SRAM write enable
mem_re_o  out  1  SRAM read enable
mem_ble_o  out  4  SRAM byte-lane enables
mem_d_o  out  32  SRAM write data
mem_add_o  out  $clog2(SIZE)  SRAM word index
mem_d_i  in  32  SRAM asynchronous read data

Behaviour:
- Reset (async, rst_ni=0): i_rvalid_o, d_rvalid_o, i_err_o, d_err_o = 0; i_rdata_o, d_rdata_o = 0; starvation counter = 0. Any pending response is dropped.
- Arbitration is combinational, and at most one grant is issued per cycle.
  - Only one req: that port is granted.
  - Both req, counter < STARVE_LIMIT: d granted.
  - Both req, counter >= STARVE_LIMIT: i granted.
- Starvation counter:
  - +1 (saturating at STARVE_LIMIT) each cycle i_req_i=1 and i_gnt_o=0.
  - Cleared in any cycle i_gnt_o=1 or i_req_i=0.
- Range check: an address is in range iff addr < SIZE. mem_add_o = addr[$clog2(SIZE)-1:2] zero-extended in the top 2 bits, so word index = addr>>2. Address bits [1:0] are ignored.
- Granted in-range fetch: mem_re_o=1, mem_we_o=0, mem_ble_o=4'b1111.
- Granted in-range load: mem_re_o=1, mem_we_o=0, mem_ble_o=d_be_i.
- Granted in-range store: mem_we_o=1, mem_re_o=0, mem_ble_o=d_be_i, mem_d_o=d_wdata_i. The write commits at the same clock edge.
- Idle or out-of-range grant: mem_we_o=0, mem_re_o=0, mem_ble_o=0, mem_add_o=0, mem_d_o=0. The SRAM is never touched.
- Response timing, at the edge ending the grant cycle:
  - Granted port's rvalid <= 1.
  - rdata <= mem_d_i for in-range reads, else 0.
  - err <= out-of-range flag.
  - The non-granted port's rvalid <= 0; its rdata and err hold.
- Latency: grant in cycle N, response in cycle N+1. Back-to-back grants on one port give one response per cycle.
- Read-after-write: a store in cycle N followed by a load in cycle N+1 to the same word returns the new data.
- Lane masking comes from the SRAM (disabled lanes read 0). The arbiter does not re-mask.
- Reset mid-operation: outputs go to reset values immediately. The first post-reset grant behaves as from idle.

Decomposition:
- Package mem_arb_pkg:
  - port-select enum {PORT_NONE, PORT_I, PORT_D}
  - BE_WORD = 4'b1111
  - mem request struct {we, re, ble, add, d}
- One sub-module, mem_arb_resp_reg: response register per port (rvalid/rdata/err), instantiated twice.
- Arbitration, counter and SRAM mux stay in the top.

Test Plan:
- Word 4 preloaded 0xDEADBEEF; i_req_i=1, i_addr_i=0x10 -> i_gnt_o=1 same cycle, mem_add_o=4, mem_ble_o=1111; next cycle i_rvalid_o=1, i_rdata_o=0xDEADBEEF, i_err_o=0.
- Store d_addr_i=0x20, d_be_i=0011, d_wdata_i=0x12345678 over word 0xFFFFFFFF, then a load with be=1111 next cycle -> d_rdata_o=0xFFFF5678; the store's response has d_rvalid_o=1, d_rdata_o=0.
- i_req_i and d_req_i held high 9 cycles, STARVE_LIMIT=2 -> grant sequence D,D,I,D,D,I,D,D,I; counter cleared after each I grant.
- d load at 0x1000 with SIZE=4096 -> d_gnt_o=1, mem_re_o=0, mem_we_o=0; next cycle d_rvalid_o=1, d_err_o=1, d_rdata_o=0.
- Fetch granted, then rst_ni low before the next edge -> i_rvalid_o=0 and i_rdata_o=0 immediately, no response after release; counter=0.
- Simultaneous requests with counter=0 -> d granted, i_gnt_o=0, i_rvalid_o=0 next cycle; i granted later only when its conditions hold.
